// File: rtl/ae_multich_spectrogram_capture.sv
// Multi-channel AE spectrogram capture: synchronises band events and RTC ticks, records one
// band-activity word per channel per time bin, then streams the buffer out in SER_W-bit slices.
module ae_multich_spectrogram_capture #(
    parameter int CH          = 2,
    parameter int BANDS       = 8,
    parameter int DEPTH       = 16,
    parameter int SER_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [CH*BANDS-1:0]   ev_in_i,
    input  logic                  rtc_tick_i,
    input  logic                  trig_mode_i,
    input  logic                  rd_start_i,
    input  logic                  rd_en_i,
    output logic [SER_W-1:0]      ser_out_o,
    output logic                  ser_valid_o,
    output logic                  sl_time_o,
    output logic                  sl_ch_o,
    output logic                  sig_det_o,
    output logic                  mem_done_o,
    output logic                  reading_o
);

    localparam int W      = CH * BANDS;
    localparam int SLICES = BANDS / SER_W;
    localparam int SLW    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW     = $clog2(DEPTH);

    // ARMED wait for trigger | CAPTURE fill bins on ticks | DONE hold buffer | READ stream out
    typedef enum logic [1:0] {ARMED, CAPTURE, DONE, READ} state_t;

    state_t                           state_q;
    logic [SYNC_STAGES-1:0][W-1:0]    ev_sync_q;
    logic [SYNC_STAGES-1:0]           tick_sync_q;
    logic                             tick_prev_q;
    logic [W-1:0]                     acc_q;
    logic [BW-1:0]                    bin_q;
    logic [CHW-1:0]                   ch_q;
    logic [SLW-1:0]                   slice_q;
    logic [SER_W-1:0]                 ser_out_q;
    logic                             ser_valid_q;
    logic                             sl_time_q;
    logic                             sl_ch_q;
    logic                             sig_det_q;
    logic                             mem_done_q;
    logic                             reading_q;
    logic [W-1:0]                     mem_q [DEPTH];

    logic [W-1:0]     ev;
    logic             ev_any;
    logic             tick;
    logic [W-1:0]     acc_d;
    logic             mem_we;
    logic             last_slice;
    logic             last_ch;
    logic             last_bin;
    logic [W-1:0]     rd_row;
    logic [BANDS-1:0] rd_word;
    logic [SER_W-1:0] slice_d;

    assign ev         = ev_sync_q[SYNC_STAGES-1];
    assign ev_any     = |ev;
    assign tick       = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign acc_d      = acc_q | ev;
    assign mem_we     = (state_q == CAPTURE) && tick;
    assign last_slice = (slice_q == SLW'(SLICES - 1));
    assign last_ch    = (ch_q == CHW'(CH - 1));
    assign last_bin   = (bin_q == BW'(DEPTH - 1));
    assign rd_row     = mem_q[bin_q];

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < CH; c++) begin
            if (ch_q == CHW'(c)) rd_word = rd_row[c*BANDS +: BANDS];
        end
        slice_d = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (slice_q == SLW'(s)) slice_d = rd_word[BANDS-1-s*SER_W -: SER_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ev_sync_q   <= '0;
            tick_sync_q <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            ev_sync_q   <= {ev_sync_q[SYNC_STAGES-2:0], ev_in_i};
            tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], rtc_tick_i};
            tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
        end
    end

    // The tick cycle's own events belong to the bin being closed.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[bin_q] <= acc_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ARMED;
            acc_q       <= '0;
            bin_q       <= '0;
            ch_q        <= '0;
            slice_q     <= '0;
            ser_out_q   <= '0;
            ser_valid_q <= 1'b0;
            sl_time_q   <= 1'b0;
            sl_ch_q     <= 1'b0;
            sig_det_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            reading_q   <= 1'b0;
        end else begin
            ser_valid_q <= 1'b0;
            sl_time_q   <= 1'b0;
            sl_ch_q     <= 1'b0;
            case (state_q)
                ARMED: begin
                    if (trig_mode_i || ev_any) begin
                        state_q   <= CAPTURE;
                        acc_q     <= acc_d;
                        bin_q     <= '0;
                        sig_det_q <= ev_any;
                    end
                end
                CAPTURE: begin
                    if (ev_any) sig_det_q <= 1'b1;
                    if (tick) begin
                        acc_q <= '0;
                        if (last_bin) begin
                            state_q    <= DONE;
                            mem_done_q <= 1'b1;
                        end else begin
                            bin_q <= bin_q + BW'(1);
                        end
                    end else begin
                        acc_q <= acc_d;
                    end
                end
                DONE: begin
                    if (rd_start_i) begin
                        state_q   <= READ;
                        reading_q <= 1'b1;
                        bin_q     <= '0;
                        ch_q      <= '0;
                        slice_q   <= '0;
                    end
                end
                READ: begin
                    if (rd_en_i) begin
                        ser_valid_q <= 1'b1;
                        ser_out_q   <= slice_d;
                        sl_ch_q     <= (slice_q == '0);
                        sl_time_q   <= (slice_q == '0) && (ch_q == '0);
                        if (last_slice) begin
                            slice_q <= '0;
                            if (last_ch) begin
                                ch_q <= '0;
                                if (last_bin) begin
                                    state_q    <= ARMED;
                                    reading_q  <= 1'b0;
                                    mem_done_q <= 1'b0;
                                    sig_det_q  <= 1'b0;
                                    acc_q      <= '0;
                                end else begin
                                    bin_q <= bin_q + BW'(1);
                                end
                            end else begin
                                ch_q <= ch_q + CHW'(1);
                            end
                        end else begin
                            slice_q <= slice_q + SLW'(1);
                        end
                    end
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign ser_out_o   = ser_out_q;
    assign ser_valid_o = ser_valid_q;
    assign sl_time_o   = sl_time_q;
    assign sl_ch_o     = sl_ch_q;
    assign sig_det_o   = sig_det_q;
    assign mem_done_o  = mem_done_q;
    assign reading_o   = reading_q;

endmodule

// File: tb/tb_ae_multich_spectrogram_capture.sv
// Scoreboard bench for ae_multich_spectrogram_capture: builds the expected buffer from the
// injected events/ticks and checks every readout beat against it.
module tb_ae_multich_spectrogram_capture;

    localparam int CH = 2, BANDS = 8, DEPTH = 16, SER_W = 2, SYNC_STAGES = 2;

    typedef struct packed {
        logic [1:0] d;
        logic       t;
        logic       c;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ev_in;
    logic        rtc_tick, trig_mode, rd_start, rd_en;
    logic [1:0]  ser_out;
    logic        ser_valid, sl_time, sl_ch, sig_det, mem_done, reading;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_mem [DEPTH][CH];
    beat_t      sb [$];

    ae_multich_spectrogram_capture #(
        .CH(CH), .BANDS(BANDS), .DEPTH(DEPTH), .SER_W(SER_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ev_in_i(ev_in), .rtc_tick_i(rtc_tick),
        .trig_mode_i(trig_mode), .rd_start_i(rd_start), .rd_en_i(rd_en),
        .ser_out_o(ser_out), .ser_valid_o(ser_valid), .sl_time_o(sl_time), .sl_ch_o(sl_ch),
        .sig_det_o(sig_det), .mem_done_o(mem_done), .reading_o(reading)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'((k * 53 + seed * 29 + 17) & 255);
    endfunction

    task automatic clear_model();
        for (int b = 0; b < DEPTH; b++)
            for (int c = 0; c < CH; c++) exp_mem[b][c] = 8'h00;
    endtask

    task automatic ev_pulse(input int ch, input logic [7:0] val);
        ev_in = '0;
        ev_in[ch*8 +: 8] = val;
        cyc(1);
        ev_in = '0;
    endtask

    task automatic tick_only();
        rtc_tick = 1'b1;
        cyc(2);
        rtc_tick = 1'b0;
        cyc(2);
    endtask

    task automatic tick_with_event(input int ch, input logic [7:0] val);
        ev_in = '0;
        ev_in[ch*8 +: 8] = val;
        rtc_tick = 1'b1;
        cyc(1);
        ev_in = '0;
        cyc(1);
        rtc_tick = 1'b0;
        cyc(2);
    endtask

    // Bins k0..k1: optional events before each tick, updating the expected buffer.
    task automatic run_ticks(input int seed, input bit with_ev, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            if (with_ev) begin
                ev_pulse(k % 2, pat(seed, k));
                exp_mem[k][k % 2] |= pat(seed, k);
                if (k == 7) begin
                    ev_pulse(1, 8'h81);
                    exp_mem[k][1] |= 8'h81;
                end
            end
            cyc(1);
            if (with_ev && k == 4) begin
                tick_with_event(1, 8'hA0);
                exp_mem[k][1] |= 8'hA0;
            end else begin
                tick_only();
            end
        end
    endtask

    task automatic push_expected();
        beat_t e;
        for (int b = 0; b < DEPTH; b++)
            for (int c = 0; c < CH; c++)
                for (int s = 0; s < BANDS / SER_W; s++) begin
                    e.d = 2'((exp_mem[b][c] >> (6 - 2 * s)) & 8'h03);
                    e.t = (s == 0 && c == 0);
                    e.c = (s == 0);
                    sb.push_back(e);
                end
    endtask

    task automatic read_stream(input bit stall, input int max_beats, output int beats);
        beat_t      e;
        int         budget = 1000;
        int         i = 0;
        logic [1:0] last_d = '0;
        bit         seen = 0;
        beats = 0;
        push_expected();
        rd_start = 1'b1;
        cyc(1);
        rd_start = 1'b0;
        n_checks++;
        if (reading !== 1'b1) begin
            n_fail++;
            $display("FAIL read_enter: reading=%b expected 1", reading);
        end
        while (sb.size() > 0 && beats < max_beats && budget > 0) begin
            rd_en = stall ? (i % 3 != 1) : 1'b1;
            i++;
            budget--;
            cyc(1);
            n_checks++;
            if (ser_valid !== rd_en) begin
                n_fail++;
                $display("FAIL valid_track: ser_valid=%b expected %b (step %0d)", ser_valid, rd_en, i);
            end
            if (ser_valid === 1'b1) begin
                e = sb.pop_front();
                n_checks++;
                if ({ser_out, sl_time, sl_ch} !== {e.d, e.t, e.c}) begin
                    n_fail++;
                    $display("FAIL beat%0d: out=%b t=%b c=%b expected out=%b t=%b c=%b",
                             beats, ser_out, sl_time, sl_ch, e.d, e.t, e.c);
                end
                beats++;
                last_d = ser_out;
                seen = 1;
            end else begin
                n_checks++;
                if ({sl_time, sl_ch} !== 2'b00 || (seen && ser_out !== last_d)) begin
                    n_fail++;
                    $display("FAIL stall_hold: out=%b t=%b c=%b expected out=%b t=0 c=0",
                             ser_out, sl_time, sl_ch, last_d);
                end
            end
        end
        rd_en = 1'b0;
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_timeout: %0d beats left, expected 0", sb.size());
        end
    endtask

    task automatic check_idle_after_read(input string tag);
        cyc(1);
        n_checks++;
        if ({mem_done, reading, sig_det, ser_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_end: done=%b rd=%b det=%b vld=%b expected all 0",
                     tag, mem_done, reading, sig_det, ser_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ev_in = '0; rtc_tick = 0; trig_mode = 0; rd_start = 0; rd_en = 0;
        cyc(2);
        n_checks++;
        if ({ser_out, ser_valid, sl_time, sl_ch, sig_det, mem_done, reading} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: %b expected 00000000",
                     {ser_out, ser_valid, sl_time, sl_ch, sig_det, mem_done, reading});
        end
        rst_n = 1'b1;
        cyc(3);
        n_checks++;
        if ({sig_det, reading, mem_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL armed_idle: det=%b rd=%b done=%b expected 0", sig_det, reading, mem_done);
        end
    endtask

    task automatic test_trigger();
        clear_model();
        ev_pulse(1, 8'h08);
        exp_mem[0][1] |= 8'h08;
        cyc(1);
        n_checks++;
        if (sig_det !== 1'b0) begin
            n_fail++;
            $display("FAIL sig_det_early: %b expected 0", sig_det);
        end
        cyc(1);
        n_checks++;
        if (sig_det !== 1'b1) begin
            n_fail++;
            $display("FAIL sig_det_latency: %b expected 1", sig_det);
        end
        n_checks++;
        if ({mem_done, reading} !== 2'b00) begin
            n_fail++;
            $display("FAIL capture_flags: done=%b rd=%b expected 0", mem_done, reading);
        end
    endtask

    task automatic test_boundary();
        run_ticks(1, 1, 0, DEPTH - 2);
        cyc(3);
        n_checks++;
        if (mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early: mem_done=%b expected 0", mem_done);
        end
        run_ticks(1, 1, DEPTH - 1, DEPTH - 1);
        cyc(3);
        n_checks++;
        if (mem_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_set: mem_done=%b expected 1", mem_done);
        end
        ev_pulse(0, 8'hFF);
        tick_with_event(1, 8'hFF);
        tick_only();
        cyc(3);
        n_checks++;
        if ({mem_done, sig_det, reading} !== 3'b110) begin
            n_fail++;
            $display("FAIL done_hold: done=%b det=%b rd=%b expected 1 1 0", mem_done, sig_det, reading);
        end
    endtask

    task automatic test_readout();
        int beats;
        read_stream(1'b0, 100000, beats);
        n_checks++;
        if (beats !== DEPTH * CH * BANDS / SER_W) begin
            n_fail++;
            $display("FAIL beat_count: %0d expected %0d", beats, DEPTH * CH * BANDS / SER_W);
        end
        check_idle_after_read("readout");
    endtask

    task automatic test_trig_mode();
        int beats;
        clear_model();
        trig_mode = 1'b1;
        cyc(1);
        trig_mode = 1'b0;
        rd_en = 1'b1;
        rd_start = 1'b1;
        cyc(1);
        rd_start = 1'b0;
        cyc(2);
        n_checks++;
        if ({reading, mem_done, ser_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_ignored: rd=%b done=%b vld=%b expected 0", reading, mem_done, ser_valid);
        end
        rd_en = 1'b0;
        run_ticks(0, 0, 0, DEPTH - 1);
        cyc(3);
        n_checks++;
        if ({mem_done, sig_det} !== 2'b10) begin
            n_fail++;
            $display("FAIL trig1_done: done=%b det=%b expected 1 0", mem_done, sig_det);
        end
        read_stream(1'b0, 100000, beats);
        n_checks++;
        if (beats !== DEPTH * CH * BANDS / SER_W) begin
            n_fail++;
            $display("FAIL trig1_beats: %0d expected %0d", beats, DEPTH * CH * BANDS / SER_W);
        end
        check_idle_after_read("trig1");
    endtask

    task automatic test_reset_mid_read();
        int beats;
        clear_model();
        trig_mode = 1'b1;
        cyc(1);
        trig_mode = 1'b0;
        run_ticks(0, 0, 0, DEPTH - 1);
        cyc(3);
        read_stream(1'b0, 10, beats);
        rd_en = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_out, ser_valid, sl_time, sl_ch, sig_det, mem_done, reading} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_read: %b expected 00000000",
                     {ser_out, ser_valid, sl_time, sl_ch, sig_det, mem_done, reading});
        end
        sb.delete();
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        n_checks++;
        if ({reading, mem_done, ser_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: rd=%b done=%b vld=%b expected 0", reading, mem_done, ser_valid);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back_stall();
        int beats;
        clear_model();
        ev_pulse(0, 8'h3C);
        exp_mem[0][0] |= 8'h3C;
        cyc(2);
        run_ticks(2, 1, 0, DEPTH - 1);
        cyc(3);
        n_checks++;
        if ({mem_done, sig_det} !== 2'b11) begin
            n_fail++;
            $display("FAIL recapture_done: done=%b det=%b expected 1 1", mem_done, sig_det);
        end
        read_stream(1'b1, 100000, beats);
        n_checks++;
        if (beats !== DEPTH * CH * BANDS / SER_W) begin
            n_fail++;
            $display("FAIL stall_beats: %0d expected %0d", beats, DEPTH * CH * BANDS / SER_W);
        end
        check_idle_after_read("stall");
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_boundary();
        test_readout();
        test_trig_mode();
        test_reset_mid_read();
        test_back_to_back_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
